// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 64;

  localparam logic IF_PORT  = 1'b0;
  localparam logic LSU_PORT = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  // Access attributes latched at grant.
  typedef struct packed {
    logic owner;
    logic we;
    logic oor;
  } acc_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the fetch and load/store ports.
// DMEM_ARB_RR_EN selects round-robin; otherwise the load/store port always wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef DMEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic win0_o,
  output logic win1_o
);

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    // On a tie, the port that was not granted last goes next.
    win1_o = req1_i & (~req0_i | (last_i != LSU_PORT));
`else
    win1_o = req1_i;
`endif
    win0_o = req0_i & ~win1_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 1 priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [63:0]       addr0,
  input  logic [63:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [63:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  acc_t                acc_q, acc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [63:0]         addr_sel;
  logic [DATA_W-1:0]   resp;
  logic                upd;
  logic                win0, win1;
`ifdef DMEM_ARB_RR_EN
  logic                ptr_q, ptr_d;
`endif

  dmem_arb_pick u_pick (
    .req0_i (req0),
    .req1_i (req1),
`ifdef DMEM_ARB_RR_EN
    .last_i (ptr_q),
`endif
    .win0_o (win0),
    .win1_o (win1)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
`ifdef DMEM_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    addr_sel  = win1 ? addr1 : addr0;
    resp      = '0;
    upd       = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (win0 | win1) begin
          gnt0      = win0;
          gnt1      = win1;
          acc_d.owner = win1 ? LSU_PORT : IF_PORT;
          acc_d.we    = win1 ? we1 : we0;
          acc_d.oor   = |addr_sel[63:ADDR_W];
          addr_d    = addr_sel[ADDR_W-1:0];
          wdata_d   = win1 ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
          ptr_d     = win1 ? LSU_PORT : IF_PORT;
`endif
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Out-of-range accesses never touch the memory.
        mem_write = acc_q.we & ~acc_q.oor;
        mem_read  = ~acc_q.we & ~acc_q.oor;
        state_d   = RESP;
      end
      RESP: begin
        resp = acc_q.oor ? '0 : mem_rdata;
        upd  = acc_q.oor | ~acc_q.we;
        if (acc_q.owner == LSU_PORT) begin
          done1 = 1'b1;
          err1  = acc_q.oor;
          if (upd) rdata1_d = resp;
        end else begin
          done0 = 1'b1;
          err0  = acc_q.oor;
          if (upd) rdata0_d = resp;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end

    // Read data bypasses the register so it is valid in the done cycle.
    rdata0 = rdata0_d;
    rdata1 = rdata1_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q    <= LSU_PORT;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign mem_addr  = 64'(addr_q);
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus randomized accesses
// checked against a transaction-level memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: intended memory contents, last read value per port, last grant.
  logic [63:0] ref_mem [32];
  logic [63:0] ref_rd  [2];
  bit          last;

  // Memory the DUT actually drives.
  logic [63:0] mem [32];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[4:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'(i);
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    last = 1'b1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the first cycle after done.
  task automatic access(input bit p, input bit w, input logic [63:0] a,
                        input logic [63:0] d, input bit poke);
    bit oor;
    oor = (a >> 5) != 0;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    @(negedge clk);
    chkb("gnt0_T", gnt0, !p);
    chkb("gnt1_T", gnt1, p);
    chkb("rd_T", mem_read, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (poke) begin if (p) req0 = 1'b1; else req1 = 1'b1; end
    @(negedge clk);
    chkb("gnt0_T1", gnt0, 1'b0);
    chkb("gnt1_T1", gnt1, 1'b0);
    chkb("mem_read_T1", mem_read, !w && !oor);
    chkb("mem_write_T1", mem_write, w && !oor);
    if (!oor) chkw("mem_addr_T1", mem_addr, a);
    if (w && !oor) chkw("mem_wdata_T1", mem_wdata, d);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    if (oor)     ref_rd[p] = '0;
    else if (!w) ref_rd[p] = ref_mem[a[4:0]];
    else         ref_mem[a[4:0]] = d;
    chkb("done0_T2", done0, !p);
    chkb("done1_T2", done1, p);
    chkb("err0_T2", err0, !p && oor);
    chkb("err1_T2", err1, p && oor);
    chkb("strobe_T2", mem_read | mem_write, 1'b0);
    chkb("gnt_T2", gnt0 | gnt1, 1'b0);
    chkw("rdata0_T2", rdata0, ref_rd[0]);
    chkw("rdata1_T2", rdata1, ref_rd[1]);
    if (!oor) chkw("mem_addr_T2", mem_addr, a);
    last = p;
    @(posedge clk); #1;
  endtask

  initial begin
    bit          p, w, poke, wexp;
    logic [63:0] a, d;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chkb("rst_gnt", gnt0 | gnt1, 1'b0);
    chkb("rst_done", done0 | done1, 1'b0);
    chkb("rst_err", err0 | err1, 1'b0);
    chkb("rst_strobe", mem_read | mem_write, 1'b0);
    chkw("rst_rdata0", rdata0, '0);
    chkw("rst_rdata1", rdata1, '0);
    chkw("rst_mem_addr", mem_addr, '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read, write-then-read, out-of-range read.
    access(1'b0, 1'b0, 64'd7, 64'd0, 1'b0);
    access(1'b1, 1'b1, 64'd3, 64'hDEAD, 1'b0);
    access(1'b1, 1'b0, 64'd3, 64'd0, 1'b0);
    chkw("wr_rd_dead", rdata1, 64'hDEAD);
    access(1'b0, 1'b0, 64'd32, 64'd0, 1'b0);
    chkw("oor_rdata0", rdata0, '0);

    // Withdrawn request: req1 pulses only while port 0 is in ISSUE.
    access(1'b0, 1'b0, 64'd9, 64'd0, 1'b1);
    @(negedge clk);
    chkb("withdrawn_gnt1", gnt1, 1'b0);
    @(posedge clk); #1;

    // Randomized single-requester accesses.
    for (int k = 0; k < 40; k++) begin
      p    = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      poke = ($urandom_range(0, 3) == 0);
      d    = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) a = {$urandom, $urandom} | 64'h20;
      else                           a = 64'($urandom_range(0, 31));
      access(p, w, a, d, poke);
    end

    // Reset asserted during ISSUE: access is dropped, no done.
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5;
    @(negedge clk);
    chkb("rstiss_gnt0", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chkb("rstiss_done", done0 | done1, 1'b0);
    chkb("rstiss_err", err0 | err1, 1'b0);
    chkb("rstiss_strobe", mem_read | mem_write, 1'b0);
    chkw("rstiss_rdata0", rdata0, '0);
    chkw("rstiss_mem_addr", mem_addr, '0);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 64'd12, 64'd0, 1'b0);

    // Contention from a fresh reset: both requests held for four grants.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd2;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      wexp = ~last;
`else
      wexp = 1'b1;
`endif
      @(negedge clk);
      chkb("cont_gnt0", gnt0, !wexp);
      chkb("cont_gnt1", gnt1, wexp);
      @(posedge clk); #1;
      @(negedge clk);
      chkb("cont_mem_read", mem_read, 1'b1);
      chkw("cont_mem_addr", mem_addr, wexp ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      ref_rd[wexp] = ref_mem[wexp ? 2 : 1];
      chkb("cont_done0", done0, !wexp);
      chkb("cont_done1", done1, wexp);
      chkw("cont_rdata0", rdata0, ref_rd[0]);
      chkw("cont_rdata1", rdata1, ref_rd[1]);
      last = wexp;
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chkb("cont_idle_gnt", gnt0 | gnt1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
